// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_pkg : shared state encoding, time-field limits and wrap helpers.    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package clock_pkg;

    localparam int TIME_W = 7;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_e;

    localparam logic [TIME_W-1:0] HOUR_MAX = TIME_W'(23);
    localparam logic [TIME_W-1:0] MIN_MAX  = TIME_W'(59);

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v >= max) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return ((v == '0) || (v > max)) ? max : v - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_debounce : 2-flop synchronizer, stable-count debounce, press pulse.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == c_cnt_last) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | time_set_ctrl : button-driven hour/minute editor that loads the clock.    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_min,
    output logic [TIME_W-1:0] set_hour,
    output logic [TIME_W-1:0] set_min,
    output logic [TIME_W-1:0] set_sec,
    output logic              load,
    output logic [1:0]        editing,
    output logic              blink
);

    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [REP_W-1:0] c_rep_last = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [BLK_W-1:0] c_blk_last = BLK_W'(BLINK_CYCLES - 1);

    logic                  mode_level_unused;
    logic                  mode_press;
    logic [1:0]            btn_level, btn_press;   // [0]=up, [1]=down
    logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]            rep_fire_q, rep_fire_d;
    logic [1:0]            step;
    logic                  step_up, step_dn, applied;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] hour_q, hour_d, min_q, min_d;
    logic              load_q, load_d;
    logic              blink_q, blink_d;
    logic [BLK_W-1:0]  bcnt_q, bcnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level_unused), .press(mode_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .raw(btn_up), .level(btn_level[0]), .press(btn_press[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .raw(btn_down), .level(btn_level[1]), .press(btn_press[1])
    );

    // Repeat timing restarts on the press pulse; a pending repeat is dropped once the level falls.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_fire_d[i] = 1'b0;
            rep_cnt_d[i]  = '0;
            if (btn_level[i] && !btn_press[i]) begin
                if (rep_cnt_q[i] == c_rep_last) begin
                    rep_fire_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                end
            end
            step[i] = btn_press[i] | (rep_fire_q[i] & btn_level[i]);
        end
        step_up = step[0] & ~step[1];
        step_dn = step[1] & ~step[0];
    end

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        load_d  = 1'b0;
        applied = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d = ST_SET_HOUR;
                    hour_d  = (cur_hour > HOUR_MAX) ? '0 : cur_hour;
                    min_d   = (cur_min > MIN_MAX) ? '0 : cur_min;
                end
            end
            ST_SET_HOUR: begin
                if (mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (step_up) begin
                    hour_d  = wrap_inc(hour_q, HOUR_MAX);
                    applied = 1'b1;
                end else if (step_dn) begin
                    hour_d  = wrap_dec(hour_q, HOUR_MAX);
                    applied = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (step_up) begin
                    min_d   = wrap_inc(min_q, MIN_MAX);
                    applied = 1'b1;
                end else if (step_dn) begin
                    min_d   = wrap_dec(min_q, MIN_MAX);
                    applied = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Restart with digits lit on any entry or step so the edited value stays readable.
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (state_d != ST_RUN) begin
            if ((state_d != state_q) || applied) begin
                blink_d = 1'b1;
            end else if (bcnt_q == c_blk_last) begin
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                blink_d = blink_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            hour_q     <= '0;
            min_q      <= '0;
            load_q     <= 1'b0;
            blink_q    <= 1'b0;
            bcnt_q     <= '0;
            rep_cnt_q  <= '0;
            rep_fire_q <= '0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            load_q     <= load_d;
            blink_q    <= blink_d;
            bcnt_q     <= bcnt_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_fire_q <= rep_fire_d;
        end
    end

    assign set_hour = hour_q;
    assign set_min  = min_q;
    assign set_sec  = '0;
    assign load     = load_q;
    assign editing  = state_q;
    assign blink    = blink_q;

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven time-setting controller: the writer side of the clock's time counter, which it loads with user-entered hour and minute values.
- Takes three raw push-buttons (mode, up, down), debounces them and steps through RUN -> SET_HOUR -> SET_MIN -> RUN.
- Drives a one-cycle load strobe with the new time (seconds forced to 0) into the time generator, plus blink and editing flags for the 7-segment display path.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a raw button must hold a stable level before its debounced level changes.
- BLINK_CYCLES, 25000000, half-period of the blink output, in cycles.
- REPEAT_CYCLES, 25000000, cycles that up or down must be held before auto-repeat starts; auto-repeat then steps once per REPEAT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk
- btn_up  in  1  raw increment button, active-high
- btn_down  in  1  raw decrement button, active-high
- cur_hour  in  7  running hour from time generator, 0..23
- cur_min  in  7  running minute, 0..59
- set_hour  out  7  hour value being edited or loaded
- set_min  out  7  minute value being edited or loaded
- set_sec  out  7  seconds load value; constant 0
- load  out  1  one-cycle strobe: time generator takes set_hour/set_min/set_sec
- editing  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
- blink  out  1  toggles every BLINK_CYCLES while editing; 0 in RUN

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, set_hour=0, set_min=0, set_sec=0, load=0, editing=0, blink=0. All debounce, repeat and blink counters clear, and debounced levels become 0.
- Input path per button:
  - 2-flop synchronizer, then debounce.
  - Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level gives a one-cycle press pulse.
  - Latency from a stable raw edge to the press pulse is 2+DEBOUNCE_CYCLES+1 cycles.
- Auto-repeat (up/down only): while a debounced level stays high, one extra step pulse fires every REPEAT_CYCLES after the initial press. The repeat counter clears on release.
- FSM:
  - RUN: mode press -> SET_HOUR. On the transition, set_hour<=cur_hour and set_min<=cur_min (snapshot). up/down are ignored.
  - SET_HOUR: up step gives set_hour+1, wrapping 23->0. down step gives set_hour-1, wrapping 0->23. Mode press -> SET_MIN.
  - SET_MIN: same rules on set_min, wrapping 59->0 and 0->59. Mode press -> RUN with load=1 for exactly the transition cycle.
- load is registered: it asserts in the first cycle editing reads 0 and deasserts the next cycle. set_* are stable during load and hold afterwards.
- Simultaneous events:
  - up and down steps in the same cycle: no change.
  - Mode press in the same cycle as a step: mode wins, the step is dropped and the field is unchanged.
- Out-of-range snapshot (cur_hour>23 or cur_min>59) is clamped to 0 at snapshot.
- blink counter runs only in SET_HOUR/SET_MIN. It restarts from 0 with blink=1 on every state change and on every applied step, so the edited digits stay visible while stepping.
- Reset mid-edit returns to RUN with no load pulse, and the edit is discarded.
- No load is issued except on the SET_MIN -> RUN transition.

Decomposition:
- Shared package clock_pkg holds:
  - the state encoding constants ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2;
  - HOUR_MAX=23 and MIN_MAX=59;
  - the 7-bit time-field width TIME_W=7, reused by the time generator and the bin2bcd path.
- One sub-module, btn_debounce, is instantiated three times. Parameter: DEBOUNCE_CYCLES. Ports: clk, rst, raw, level, press.
- Auto-repeat, FSM and blink live in time_set_ctrl.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8 and REPEAT_CYCLES=16.
- Reset/snapshot: release rst; cur_hour=10, cur_min=35; press mode -> editing=1, set_hour=10, set_min=35, load=0, blink=1.
- Wrap: in SET_HOUR with set_hour=23, up -> 0 and down -> 23. In SET_MIN with set_min=0, down -> 59 and up -> 0.
- Commit: from set_hour=7, set_min=42 press mode twice -> exactly one load cycle with set_hour=7, set_min=42, set_sec=0; editing=0 that cycle and after.
- Debounce/repeat:
  - a 3-cycle glitch on btn_up -> no change;
  - holding btn_up for 50 cycles in SET_MIN from 5 -> set_min=8 (initial press plus 2 repeats).
- Simultaneous: up and down pressed together -> value unchanged. Mode and up pressed together in SET_HOUR -> editing=2 and set_hour unchanged.
- Reset mid-edit: assert rst in SET_MIN with set_min=12 -> immediately editing=0, set_min=0, blink=0; no load pulse at any point.
